adc_capture_avg: RTL and testbench
==================================

Name: adc_capture_avg

Overview:
- Front-end stage directly downstream of the ADC clock PLL.
- Samples the 14-bit parallel ADC bus on CLK_ADC and converts offset-binary to two's complement.
- Holds off until the PLL reports lock and a settle period has elapsed, then streams raw samples and a boxcar average of 2^AVG_LOG2 samples.
- Also counts full-scale (clip) codes for the downstream demodulator/status logic.

Parameters:
- ADC_W, 14, ADC bus width.
- AVG_LOG2, 5, log2 of samples per average (allowed range 1..8).
- SETTLE_CYC, 1024, CLK_ADC cycles to wait after lock rises before sampling is valid (≥1).
- OFFSET_BIN, 1, 1 = ADC bus is offset binary (invert MSB); 0 = bus already two's complement.

Ports:
- CLK_ADC  in  1  sample clock, PLL c0 output.
- RST_N  in  1  asynchronous active-low reset.
- PLL_LOCK  in  1  PLL locked flag, asynchronous to logic; synchronised internally with 2 flops.
- ADC_1  in  ADC_W  raw ADC bus.
- CLR_CLIP  in  1  synchronous clear of CLIP_CNT.
- ADC_RAW  out  ADC_W  registered two's-complement sample.
- RAW_VALID  out  1  ADC_RAW is a valid post-settle sample.
- AVG_DATA  out  ADC_W  signed average.
- AVG_VALID  out  1  one-cycle strobe, AVG_DATA updated.
- CLIP_CNT  out  16  saturating count of full-scale codes.
- READY  out  1  high while in the RUN state.

Behaviour:
- Reset (RST_N low, async): all outputs 0; state IDLE; accumulator, sample counter and settle counter 0; lock synchroniser 0.
- Pipeline:
  - Every cycle, ADC_1 is registered into the input register (cycle n).
  - At cycle n+1, ADC_RAW = input register with MSB inverted if OFFSET_BIN, else passed unchanged.
  - ADC_RAW updates every cycle regardless of state.
  - RAW_VALID is driven combinationally-aligned with ADC_RAW: it is 1 only when state was RUN at the cycle the sample was converted.
- Lock synchroniser:
  - lock_s = 2-flop sync of PLL_LOCK.
  - Latency from PLL_LOCK rise to lock_s rise: 2 cycles.
- FSM:
  - IDLE: settle counter = 0. Go to SETTLE when lock_s = 1.
  - SETTLE: settle counter increments each cycle. Go to RUN when it reaches SETTLE_CYC-1. Go to IDLE if lock_s = 0.
  - RUN: READY = 1. Go to IDLE if lock_s = 0.
  - Any exit from RUN clears the accumulator and sample counter in the same cycle, and never issues an AVG_VALID. The partial average is discarded.
- Averaging:
  - Accumulator is signed, ADC_W+AVG_LOG2 bits wide, sized so it cannot overflow.
  - Each cycle with RAW_VALID = 1, ADC_RAW (sign-extended) is added.
  - On the 2^AVG_LOG2-th sample:
    - The next cycle, AVG_DATA = (acc + sample) >>> AVG_LOG2, arithmetic shift, truncating toward −inf. AVG_VALID = 1 for exactly that cycle.
    - In the same cycle the 2^AVG_LOG2-th sample is added, the accumulator reloads to 0 and the sample counter wraps to 0. No sample is dropped between windows.
  - AVG_DATA holds its value between strobes.
- Clip counting:
  - A clip is an input register code equal to all-ones or all-zeros when OFFSET_BIN = 1. When OFFSET_BIN = 0 it is 0x1FFF or 0x2000 (for ADC_W = 14).
  - Only clips with RAW_VALID = 1 are counted.
  - CLIP_CNT saturates at 0xFFFF.
  - If CLR_CLIP and a clip occur in the same cycle, CLR_CLIP wins: the result is 0 and that clip is not counted.
- Lock glitch shorter than 2 cycles may be filtered by the synchroniser. Any lock_s drop is treated as a full restart, including the settle period.

Test Plan:
- Reset/lock:
  - Stimulus: RST_N low with ADC_1 toggling; then release with PLL_LOCK = 0 for 100 cycles.
  - Required: all outputs 0; READY = 0; RAW_VALID never 1.
- Settle timing (SETTLE_CYC = 16):
  - Stimulus: raise PLL_LOCK at cycle 0.
  - Required: lock_s rises at cycle 2; READY rises at cycle 18; first RAW_VALID at cycle 19.
- Conversion and average (AVG_LOG2 = 2, OFFSET_BIN = 1):
  - Stimulus: drive ADC_1 = 0x2000, 0x2004, 0x1FFC, 0x2008.
  - Required: ADC_RAW = 0x0000, 0x0004, 0x3FFC (−4), 0x0008; AVG_DATA = 8>>>2 = 0x0002 with a single AVG_VALID.
  - Stimulus: next window all 0x1FFF.
  - Required: AVG_DATA = 0x3FFF (−1).
- Back-to-back windows:
  - Stimulus: constant 0x2010 for 32 samples with AVG_LOG2 = 2.
  - Required: exactly 8 AVG_VALID strobes, 4 cycles apart, each AVG_DATA = 0x0010.
- Lock loss mid-window:
  - Stimulus: drop PLL_LOCK after 2 samples of a 4-sample window; relock.
  - Required: no AVG_VALID for the partial window; READY low; full settle repeats; first post-relock average uses only new samples.
- Clip counter:
  - Stimulus: inject 0x3FFF ×3 and 0x0000 ×2.
  - Required: CLIP_CNT = 5.
  - Stimulus: assert CLR_CLIP coincident with a 0x3FFF sample.
  - Required: CLIP_CNT = 0.
  - Stimulus: force 70000 clips.
  - Required: CLIP_CNT = 0xFFFF.

Source files
------------

// File: rtl/adc_capture_avg.sv
// adc_capture_avg: ADC front end. Registers the parallel ADC bus and converts
// it to two's complement. After PLL lock plus a settle period it streams valid
// samples, boxcar averages of 2^AVG_LOG2 samples, and a saturating clip count.
module adc_capture_avg #(
  parameter int ADC_W      = 14,
  parameter int AVG_LOG2   = 5,
  parameter int SETTLE_CYC = 1024,
  parameter int OFFSET_BIN = 1
) (
  input  logic             CLK_ADC,
  input  logic             RST_N,
  input  logic             PLL_LOCK,
  input  logic [ADC_W-1:0] ADC_1,
  input  logic             CLR_CLIP,
  output logic [ADC_W-1:0] ADC_RAW,
  output logic             RAW_VALID,
  output logic [ADC_W-1:0] AVG_DATA,
  output logic             AVG_VALID,
  output logic [15:0]      CLIP_CNT,
  output logic             READY
);

  localparam int ACC_W  = ADC_W + AVG_LOG2;
  localparam int SCNT_W = $clog2(SETTLE_CYC + 1);

  // Full-scale codes after conversion: max positive and min negative.
  localparam logic [ADC_W-1:0] POS_FS = {1'b0, {(ADC_W-1){1'b1}}};
  localparam logic [ADC_W-1:0] NEG_FS = {1'b1, {(ADC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

  state_t             state;
  logic               sync1, lock_s;
  logic [SCNT_W-1:0]  settle_cnt;
  logic [ADC_W-1:0]   in_reg;
  logic [ADC_W-1:0]   conv;
  logic               clip;
  logic               run_keep;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sum;
  logic [AVG_LOG2-1:0] smp_cnt;

  // Offset binary -> two's complement is an MSB flip; clip detection works on
  // the converted code so both bus formats share one comparator pair.
  always_comb begin
    conv = in_reg;
    if (OFFSET_BIN != 0) conv[ADC_W-1] = ~in_reg[ADC_W-1];
    clip     = (conv == POS_FS) || (conv == NEG_FS);
    run_keep = (state == RUN) && lock_s;
    sum      = acc + {{AVG_LOG2{ADC_RAW[ADC_W-1]}}, ADC_RAW};
  end

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge CLK_ADC or negedge RST_N) begin
    if (!RST_N) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= PLL_LOCK;
      lock_s <= sync1;
    end
  end

  // Lock/settle FSM. The cycle IDLE sees lock_s counts as the first settle
  // cycle, so RUN starts SETTLE_CYC cycles after lock_s rises.
  always_ff @(posedge CLK_ADC or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      settle_cnt <= '0;
      READY      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          settle_cnt <= '0;
          READY      <= 1'b0;
          if (lock_s) begin
            state      <= SETTLE;
            settle_cnt <= SCNT_W'(1);
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            state      <= IDLE;
            settle_cnt <= '0;
          end else if (int'(settle_cnt) >= SETTLE_CYC - 1) begin
            state      <= RUN;
            READY      <= 1'b1;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state <= IDLE;
            READY <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          READY <= 1'b0;
        end
      endcase
    end
  end

  // Input register and conversion stage; runs every cycle, valid tags RUN.
  always_ff @(posedge CLK_ADC or negedge RST_N) begin
    if (!RST_N) begin
      in_reg    <= '0;
      ADC_RAW   <= '0;
      RAW_VALID <= 1'b0;
    end else begin
      in_reg    <= ADC_1;
      ADC_RAW   <= conv;
      RAW_VALID <= (state == RUN);
    end
  end

  // Boxcar accumulator. Leaving RUN (or not being in it) discards the partial
  // window, including the one trailing valid sample converted before the exit.
  always_ff @(posedge CLK_ADC or negedge RST_N) begin
    if (!RST_N) begin
      acc       <= '0;
      smp_cnt   <= '0;
      AVG_DATA  <= '0;
      AVG_VALID <= 1'b0;
    end else begin
      AVG_VALID <= 1'b0;
      if (!run_keep) begin
        acc     <= '0;
        smp_cnt <= '0;
      end else if (RAW_VALID) begin
        if (smp_cnt == '1) begin
          // Upper bits of the sum are the arithmetic shift by AVG_LOG2.
          AVG_DATA  <= sum[ACC_W-1:AVG_LOG2];
          AVG_VALID <= 1'b1;
          acc       <= '0;
          smp_cnt   <= '0;
        end else begin
          acc     <= sum;
          smp_cnt <= smp_cnt + 1'b1;
        end
      end
    end
  end

  // Saturating clip counter; a clear beats a coincident clip.
  always_ff @(posedge CLK_ADC or negedge RST_N) begin
    if (!RST_N) begin
      CLIP_CNT <= '0;
    end else if (CLR_CLIP) begin
      CLIP_CNT <= '0;
    end else if ((state == RUN) && clip && (CLIP_CNT != 16'hFFFF)) begin
      CLIP_CNT <= CLIP_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_adc_capture_avg.sv
// Directed bench for adc_capture_avg (AVG_LOG2=2, SETTLE_CYC=16, offset binary).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_adc_capture_avg;

  logic        CLK_ADC;
  logic        RST_N;
  logic        PLL_LOCK;
  logic [13:0] ADC_1;
  logic        CLR_CLIP;
  logic [13:0] ADC_RAW;
  logic        RAW_VALID;
  logic [13:0] AVG_DATA;
  logic        AVG_VALID;
  logic [15:0] CLIP_CNT;
  logic        READY;

  int n_vec = 0;
  int n_err = 0;

  adc_capture_avg #(
    .ADC_W(14), .AVG_LOG2(2), .SETTLE_CYC(16), .OFFSET_BIN(1)
  ) dut (
    .CLK_ADC(CLK_ADC), .RST_N(RST_N), .PLL_LOCK(PLL_LOCK), .ADC_1(ADC_1),
    .CLR_CLIP(CLR_CLIP), .ADC_RAW(ADC_RAW), .RAW_VALID(RAW_VALID),
    .AVG_DATA(AVG_DATA), .AVG_VALID(AVG_VALID), .CLIP_CNT(CLIP_CNT),
    .READY(READY)
  );

  initial CLK_ADC = 1'b0;
  always #5 CLK_ADC = ~CLK_ADC;

  typedef struct {
    logic [13:0] adc;   // driven before this row's rising edge
    logic [13:0] raw;   // expected ADC_RAW after the edge
    logic        rv;
    logic        avld;
    logic [13:0] avg;
  } vec_t;

  vec_t tbl[9];

  task automatic step();
    @(posedge CLK_ADC);
    @(negedge CLK_ADC);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int lock_first, ready_first, rv_early, idle_bad;
    int strobes, last_strobe, gap_bad, data_bad, spur, rdy_bad, rdy_rise;

    tbl[0] = '{14'h2004, 14'h0000, 1'b1, 1'b0, 14'h0000};
    tbl[1] = '{14'h1FFC, 14'h0004, 1'b1, 1'b0, 14'h0000};
    tbl[2] = '{14'h2008, 14'h3FFC, 1'b1, 1'b0, 14'h0000};
    tbl[3] = '{14'h1FFF, 14'h0008, 1'b1, 1'b0, 14'h0000};
    tbl[4] = '{14'h1FFF, 14'h3FFF, 1'b1, 1'b1, 14'h0002};
    tbl[5] = '{14'h1FFF, 14'h3FFF, 1'b1, 1'b0, 14'h0002};
    tbl[6] = '{14'h1FFF, 14'h3FFF, 1'b1, 1'b0, 14'h0002};
    tbl[7] = '{14'h2010, 14'h3FFF, 1'b1, 1'b0, 14'h0002};
    tbl[8] = '{14'h2010, 14'h0010, 1'b1, 1'b1, 14'h3FFF};

    // Reset with a toggling bus (full-scale codes must not count).
    RST_N = 1'b0; PLL_LOCK = 1'b0; CLR_CLIP = 1'b0; ADC_1 = 14'h3FFF;
    for (int i = 0; i < 6; i++) begin
      ADC_1 = i[0] ? 14'h0000 : 14'h3FFF;
      step();
    end
    chk("rst_adc_raw", ADC_RAW, 0);
    chk("rst_raw_valid", RAW_VALID, 0);
    chk("rst_avg_data", AVG_DATA, 0);
    chk("rst_avg_valid", AVG_VALID, 0);
    chk("rst_clip_cnt", CLIP_CNT, 0);
    chk("rst_ready", READY, 0);

    // Released, no lock for 100 cycles.
    RST_N = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      ADC_1 = i[0] ? 14'h3FFF : 14'h0000;
      step();
      if (READY || RAW_VALID || AVG_VALID || CLIP_CNT != 0) idle_bad++;
    end
    chk("idle_no_valid", idle_bad, 0);
    chk("idle_adc_raw_tracks", ADC_RAW, 14'h2000);

    // Lock rises before cycle 1's edge.
    PLL_LOCK = 1'b1; ADC_1 = 14'h2000;
    lock_first = -1; ready_first = -1; rv_early = 0;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (dut.lock_s && lock_first < 0) lock_first = c;
      if (READY && ready_first < 0) ready_first = c;
      if (RAW_VALID) rv_early++;
    end
    chk("lock_s_rise_cycle", lock_first, 2);
    chk("ready_rise_cycle", ready_first, 18);
    chk("raw_valid_before_19", rv_early, 0);

    // Conversion and first two averages; row 0 is cycle 19.
    for (int i = 0; i < 9; i++) begin
      ADC_1 = tbl[i].adc;
      step();
      chk($sformatf("row%0d_adc_raw", i), ADC_RAW, tbl[i].raw);
      chk($sformatf("row%0d_raw_valid", i), RAW_VALID, tbl[i].rv);
      chk($sformatf("row%0d_avg_valid", i), AVG_VALID, tbl[i].avld);
      chk($sformatf("row%0d_avg_data", i), AVG_DATA, tbl[i].avg);
    end

    // Back-to-back windows (rows 8..39 carry 0x10), then lock loss after two
    // samples of 0x1000 in the next window, relock at row 48.
    strobes = 0; last_strobe = 0; gap_bad = 0; data_bad = 0;
    spur = 0; rdy_bad = 0; rdy_rise = -1;
    for (int r = 9; r <= 70; r++) begin
      ADC_1    = (r <= 38) ? 14'h2010 : (r <= 42) ? 14'h3000 : 14'h2020;
      PLL_LOCK = !(r >= 41 && r <= 47);
      step();
      if (r <= 40) begin
        if (AVG_VALID) begin
          strobes++;
          if (AVG_DATA != 14'h0010) data_bad++;
          if (strobes > 1 && r - last_strobe != 4) gap_bad++;
          last_strobe = r;
        end
      end else if (r <= 69) begin
        if (AVG_VALID) spur++;
      end
      if (r >= 44 && r <= 64 && (READY || RAW_VALID)) rdy_bad++;
      if (r >= 48 && READY && rdy_rise < 0) rdy_rise = r;
      if (r == 70) begin
        chk("relock_avg_valid", AVG_VALID, 1);
        chk("relock_avg_data", AVG_DATA, 14'h0020);
      end
    end
    chk("b2b_strobe_count", strobes, 8);
    chk("b2b_strobe_gap", gap_bad, 0);
    chk("b2b_avg_data", data_bad, 0);
    chk("lockloss_no_avg_valid", spur, 0);
    chk("lockloss_ready_low", rdy_bad, 0);
    chk("relock_ready_cycle", rdy_rise, 65);

    // Clip counting: three max codes, two min codes.
    for (int k = 0; k < 5; k++) begin
      ADC_1 = (k < 3) ? 14'h3FFF : 14'h0000;
      step();
    end
    ADC_1 = 14'h2020;
    step();
    step();
    chk("clip_cnt_5", CLIP_CNT, 5);

    // Clear coincident with a clip sitting in the input register.
    ADC_1 = 14'h3FFF;
    step();
    ADC_1 = 14'h2020; CLR_CLIP = 1'b1;
    step();
    CLR_CLIP = 1'b0;
    step();
    chk("clr_beats_clip", CLIP_CNT, 0);

    // Saturation: 65534 clips, then 70000 total.
    ADC_1 = 14'h3FFF;
    for (int k = 0; k < 65534; k++) step();
    ADC_1 = 14'h2020;
    step();
    step();
    chk("clip_cnt_fffe", CLIP_CNT, 16'hFFFE);
    ADC_1 = 14'h0000;
    for (int k = 0; k < 4466; k++) step();
    ADC_1 = 14'h2020;
    step();
    step();
    chk("clip_cnt_saturated", CLIP_CNT, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
